// File: rtl/wave_generator_if.sv
// +----------------------------------------------------------------------------+
// | wave_generator_if : control/status bundle for wave_generator                |
// | Optional pose_edge/neg_edge present when WAVE_GEN_EDGE_FLAGS_EN is defined. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface wave_generator_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] high_cycles;
   logic [CNT_W-1:0] low_cycles;
   logic [CNT_W-1:0] num_pulses;
   logic             clock_signal;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulse_count;
`ifdef WAVE_GEN_EDGE_FLAGS_EN
   logic             pose_edge;
   logic             neg_edge;

   modport master (
      output start, stop, high_cycles, low_cycles, num_pulses,
      input  clock_signal, busy, done, pulse_count, pose_edge, neg_edge
   );
   modport slave (
      input  start, stop, high_cycles, low_cycles, num_pulses,
      output clock_signal, busy, done, pulse_count, pose_edge, neg_edge
   );
`else
   modport master (
      output start, stop, high_cycles, low_cycles, num_pulses,
      input  clock_signal, busy, done, pulse_count
   );
   modport slave (
      input  start, stop, high_cycles, low_cycles, num_pulses,
      output clock_signal, busy, done, pulse_count
   );
`endif
endinterface

`default_nettype wire

// File: rtl/wave_generator.sv
// +----------------------------------------------------------------------------+
// | wave_generator : programmable high/low pulse-train generator (IDLE/HIGH/LOW)|
// | Macro WAVE_GEN_EDGE_FLAGS_EN adds registered pose_edge/neg_edge outputs.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module wave_generator #(
   parameter int CNT_W = 8
) (
   input wire logic        clk,
   input wire logic        resetn,
   wave_generator_if.slave bus
);

   localparam logic [1:0]       c_IDLE = 2'd0;
   localparam logic [1:0]       c_HIGH = 2'd1;
   localparam logic [1:0]       c_LOW  = 2'd2;
   localparam logic [CNT_W-1:0] c_ZERO = '0;
   localparam logic [CNT_W-1:0] c_ONE  = 1;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_low;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_remain;
   logic [CNT_W-1:0] r_count;
   logic             r_stop_pending;
   logic             r_clock_signal;
   logic             r_busy;
   logic             r_done;

   logic [CNT_W-1:0] w_in_high_eff;
   logic [CNT_W-1:0] w_high_eff;
   logic [CNT_W-1:0] w_low_eff;
   logic [CNT_W-1:0] w_count_inc;
   logic             w_phase_end;
   logic             w_seq_end;
   logic             w_clk_sig;
   logic             w_busy;
   logic             w_done;

   // Zero-length phases are clamped to one cycle.
   assign w_in_high_eff = (bus.high_cycles == c_ZERO) ? c_ONE : bus.high_cycles;
   assign w_high_eff    = (r_high == c_ZERO) ? c_ONE : r_high;
   assign w_low_eff     = (r_low  == c_ZERO) ? c_ONE : r_low;
   assign w_count_inc   = r_count + c_ONE;
   assign w_phase_end   = (r_remain == c_ZERO);
   assign w_seq_end     = ((r_num != c_ZERO) && (w_count_inc == r_num))
                          || r_stop_pending || bus.stop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: if (bus.start)  w_next_state = c_HIGH;
         c_HIGH: if (w_phase_end) w_next_state = c_LOW;
         c_LOW:  if (w_phase_end) w_next_state = w_seq_end ? c_IDLE : c_HIGH;
         default: w_next_state = c_IDLE;
      endcase
   end

   // done fires in the first IDLE cycle following any busy cycle.
   always_comb begin
      w_clk_sig = (r_state == c_HIGH);
      w_busy    = (r_state != c_IDLE);
      w_done    = (r_state == c_IDLE) && r_busy;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_high         <= c_ZERO;
         r_low          <= c_ZERO;
         r_num          <= c_ZERO;
         r_remain       <= c_ZERO;
         r_count        <= c_ZERO;
         r_stop_pending <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_stop_pending <= 1'b0;
               if (bus.start) begin
                  r_high   <= bus.high_cycles;
                  r_low    <= bus.low_cycles;
                  r_num    <= bus.num_pulses;
                  r_count  <= c_ZERO;
                  r_remain <= w_in_high_eff - c_ONE;
               end
            end
            c_HIGH: begin
               if (bus.stop) r_stop_pending <= 1'b1;
               r_remain <= w_phase_end ? (w_low_eff - c_ONE) : (r_remain - c_ONE);
            end
            c_LOW: begin
               if (w_phase_end) begin
                  r_count  <= w_count_inc;
                  r_remain <= w_high_eff - c_ONE;
               end else begin
                  r_remain <= r_remain - c_ONE;
               end
               if (w_phase_end && w_seq_end) begin
                  r_stop_pending <= 1'b0;
               end else if (bus.stop) begin
                  r_stop_pending <= 1'b1;
               end
            end
            default: r_stop_pending <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_clock_signal <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_clock_signal <= w_clk_sig;
         r_busy         <= w_busy;
         r_done         <= w_done;
      end
   end

   assign bus.clock_signal = r_clock_signal;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.pulse_count  = r_count;

`ifdef WAVE_GEN_EDGE_FLAGS_EN
   logic r_pose_edge;
   logic r_neg_edge;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pose_edge <= 1'b0;
         r_neg_edge  <= 1'b0;
      end else begin
         r_pose_edge <= w_clk_sig & ~r_clock_signal;
         r_neg_edge  <= ~w_clk_sig & r_clock_signal;
      end
   end

   assign bus.pose_edge = r_pose_edge;
   assign bus.neg_edge  = r_neg_edge;
`endif

endmodule

`default_nettype wire
